// File: rtl/display_alert_arbiter.sv
// display_alert_arbiter: shares the 7-seg bank, LEDs and piezo among four blocks; edge events preempt the DIP owner.
// Latency: source buses reach the pins one cycle later; every owner change inserts BLANK_CYC blank cycles.
// Events are captured as pending bits and served round-robin; none is lost while another alert is running.
module display_alert_arbiter #(
  parameter int BLANK_CYC    = 8,
  parameter int BEEP_ON_MS   = 250,
  parameter int BEEP_OFF_MS  = 250,
  parameter int ALERT_MAX_MS = 30000,
  parameter int TONE_DIV     = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [1:0]  mode_sel,
  input  logic [31:0] src_seg_data,
  input  logic [31:0] src_seg_com,
  input  logic [31:0] src_led,
  input  logic [3:0]  evt_level,
  input  logic        ack_key,
  output logic [7:0]  seg_data,
  output logic [7:0]  seg_com,
  output logic [7:0]  led,
  output logic        piezo,
  output logic [1:0]  owner,
  output logic        alert_active,
  output logic [3:0]  evt_ack
);

  localparam logic [1:0] ST_NORMAL = 2'd0;
  localparam logic [1:0] ST_BLANK  = 2'd1;
  localparam logic [1:0] ST_ALERT  = 2'd2;

  // Where BLANK goes next; POST means "after an alert": serve the next pending event or return to mode_sel.
  localparam logic [1:0] TGT_NORMAL = 2'd0;
  localparam logic [1:0] TGT_ALERT  = 2'd1;
  localparam logic [1:0] TGT_POST   = 2'd2;

  localparam logic [3:0]  BLANK_LAST   = 4'(BLANK_CYC - 1);
  localparam logic [9:0]  BEEP_ON      = 10'(BEEP_ON_MS);
  localparam logic [9:0]  BEEP_LAST    = 10'(BEEP_ON_MS + BEEP_OFF_MS - 1);
  localparam logic [9:0]  TONE_LAST    = 10'(TONE_DIV - 1);
  localparam logic [15:0] ELAPSED_LAST = 16'(ALERT_MAX_MS - 1);

  logic [1:0]  state_q, state_d;
  logic [1:0]  target_q, target_d;
  logic [1:0]  owner_q, owner_d;
  logic [1:0]  rr_ptr_q, rr_ptr_d;
  logic [3:0]  pend_q, pend_d;
  logic [3:0]  evt_prev_q, evt_prev_d;
  logic        ack_prev_q, ack_prev_d;
  logic [3:0]  blank_cnt_q, blank_cnt_d;
  logic [9:0]  beep_cnt_q, beep_cnt_d;
  logic [9:0]  tone_cnt_q, tone_cnt_d;
  logic [15:0] elapsed_q, elapsed_d;
  logic [7:0]  seg_data_q, seg_data_d;
  logic [7:0]  seg_com_q, seg_com_d;
  logic [7:0]  led_q, led_d;
  logic        piezo_q, piezo_d;
  logic [3:0]  evt_ack_q, evt_ack_d;

  logic [3:0]  evt_rise;
  logic        ack_rise;
  logic [3:0]  pend_clr;
  logic [1:0]  pick;
  logic        show;

  // First pending source found searching ptr+1, ptr+2, ptr+3, ptr (mod 4).
  function automatic logic [1:0] rr_pick(input logic [3:0] p, input logic [1:0] ptr);
    logic [1:0] idx;
    rr_pick = ptr;
    for (int i = 4; i >= 1; i--) begin
      idx = ptr + 2'(i);
      if (p[idx]) rr_pick = idx;
    end
  endfunction

  // Next-state logic; counters hold the index of the cycle the next state is in, outputs follow the next state.
  always_comb begin
    evt_rise    = evt_level & ~evt_prev_q;
    ack_rise    = ack_key & ~ack_prev_q;
    evt_prev_d  = evt_level;
    ack_prev_d  = ack_key;
    pick        = rr_pick(pend_q, rr_ptr_q);
    state_d     = state_q;
    target_d    = target_q;
    owner_d     = owner_q;
    rr_ptr_d    = rr_ptr_q;
    blank_cnt_d = '0;
    beep_cnt_d  = '0;
    tone_cnt_d  = '0;
    elapsed_d   = '0;
    evt_ack_d   = '0;
    pend_clr    = '0;

    case (state_q)
      ST_NORMAL: begin
        if (|pend_q) begin
          owner_d  = pick;
          rr_ptr_d = pick;
          state_d  = ST_BLANK;
          target_d = TGT_ALERT;
        end else if (mode_sel != owner_q) begin
          owner_d  = mode_sel;
          state_d  = ST_BLANK;
          target_d = TGT_NORMAL;
        end
      end
      ST_BLANK: begin
        if (blank_cnt_q == BLANK_LAST) begin
          case (target_q)
            TGT_ALERT:  state_d = ST_ALERT;
            TGT_NORMAL: state_d = ST_NORMAL;
            default: begin
              // Display is already blanked, so a queued alert starts without a second blank period.
              if (|pend_q) begin
                owner_d  = pick;
                rr_ptr_d = pick;
                state_d  = ST_ALERT;
              end else begin
                owner_d  = mode_sel;
                state_d  = ST_NORMAL;
              end
            end
          endcase
        end else begin
          blank_cnt_d = blank_cnt_q + 4'd1;
        end
      end
      ST_ALERT: begin
        if (ack_rise || (elapsed_q == ELAPSED_LAST)) begin
          evt_ack_d = 4'b0001 << owner_q;
          pend_clr  = 4'b0001 << owner_q;
          state_d   = ST_BLANK;
          target_d  = TGT_POST;
        end else begin
          elapsed_d  = (elapsed_q == 16'hFFFF) ? elapsed_q : elapsed_q + 16'd1;
          beep_cnt_d = (beep_cnt_q == BEEP_LAST) ? 10'd0 : beep_cnt_q + 10'd1;
          if (beep_cnt_d == 10'd0 || tone_cnt_q == TONE_LAST) tone_cnt_d = 10'd0;
          else tone_cnt_d = tone_cnt_q + 10'd1;
        end
      end
      default: state_d = ST_NORMAL;
    endcase

    // A new edge on the bit being cleared wins.
    pend_d = (pend_q & ~pend_clr) | evt_rise;

    show       = (state_d != ST_BLANK);
    seg_data_d = show ? src_seg_data[{owner_d, 3'b000} +: 8] : 8'h00;
    seg_com_d  = show ? src_seg_com[{owner_d, 3'b000} +: 8]  : 8'hFF;
    led_d      = show ? src_led[{owner_d, 3'b000} +: 8]      : 8'h00;

    if (state_d == ST_ALERT && beep_cnt_d < BEEP_ON) begin
      if (beep_cnt_d == 10'd0)     piezo_d = 1'b1;
      else if (tone_cnt_d == 10'd0) piezo_d = ~piezo_q;
      else                          piezo_d = piezo_q;
    end else begin
      piezo_d = 1'b0;
    end
  end

  // State and output registers; reset forces the display dark and the piezo silent without a clock.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_NORMAL;
      target_q    <= TGT_NORMAL;
      owner_q     <= 2'd0;
      rr_ptr_q    <= 2'd3;
      pend_q      <= 4'h0;
      evt_prev_q  <= 4'h0;
      ack_prev_q  <= 1'b0;
      blank_cnt_q <= 4'd0;
      beep_cnt_q  <= 10'd0;
      tone_cnt_q  <= 10'd0;
      elapsed_q   <= 16'd0;
      seg_data_q  <= 8'h00;
      seg_com_q   <= 8'hFF;
      led_q       <= 8'h00;
      piezo_q     <= 1'b0;
      evt_ack_q   <= 4'h0;
    end else begin
      state_q     <= state_d;
      target_q    <= target_d;
      owner_q     <= owner_d;
      rr_ptr_q    <= rr_ptr_d;
      pend_q      <= pend_d;
      evt_prev_q  <= evt_prev_d;
      ack_prev_q  <= ack_prev_d;
      blank_cnt_q <= blank_cnt_d;
      beep_cnt_q  <= beep_cnt_d;
      tone_cnt_q  <= tone_cnt_d;
      elapsed_q   <= elapsed_d;
      seg_data_q  <= seg_data_d;
      seg_com_q   <= seg_com_d;
      led_q       <= led_d;
      piezo_q     <= piezo_d;
      evt_ack_q   <= evt_ack_d;
    end
  end

  assign seg_data     = seg_data_q;
  assign seg_com      = seg_com_q;
  assign led          = led_q;
  assign piezo        = piezo_q;
  assign owner        = owner_q;
  assign alert_active = (state_q == ST_ALERT);
  assign evt_ack      = evt_ack_q;

endmodule

// File: tb/tb_display_alert_arbiter.sv
// Directed bench for display_alert_arbiter: reset, mode change, alert with beep pattern,
// timeout, round-robin of simultaneous events and asynchronous reset in mid-alert.
module tb_display_alert_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  mode_sel;
  logic [31:0] src_seg_data, src_seg_com, src_led;
  logic [3:0]  evt_level;
  logic        ack_key;
  logic [7:0]  seg_data, seg_com, led;
  logic        piezo;
  logic [1:0]  owner;
  logic        alert_active;
  logic [3:0]  evt_ack;

  logic [7:0] sd [4];
  logic [7:0] sc [4];
  logic [7:0] sl [4];

  int total = 0;
  int bad   = 0;

  assign src_seg_data = {sd[3], sd[2], sd[1], sd[0]};
  assign src_seg_com  = {sc[3], sc[2], sc[1], sc[0]};
  assign src_led      = {sl[3], sl[2], sl[1], sl[0]};

  always #5 clk = ~clk;

  display_alert_arbiter dut (
    .clk(clk), .rst(rst), .mode_sel(mode_sel),
    .src_seg_data(src_seg_data), .src_seg_com(src_seg_com), .src_led(src_led),
    .evt_level(evt_level), .ack_key(ack_key),
    .seg_data(seg_data), .seg_com(seg_com), .led(led), .piezo(piezo),
    .owner(owner), .alert_active(alert_active), .evt_ack(evt_ack)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst = 1'b1; mode_sel = 2'd0; evt_level = 4'h0; ack_key = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    total++;
    if ({seg_data, seg_com, led, piezo, owner, alert_active, evt_ack} !== {8'h00, 8'hFF, 8'h00, 1'b0, 2'd0, 1'b0, 4'h0}) begin
      bad++;
      $display("FAIL reset_values: got %h want %h", {seg_data, seg_com, led, piezo, owner, alert_active, evt_ack},
               {8'h00, 8'hFF, 8'h00, 1'b0, 2'd0, 1'b0, 4'h0});
    end
    rst = 1'b0;
    tick;
    total++;
    if ({seg_data, seg_com, led, owner, piezo} !== {8'h3F, 8'h7F, 8'h01, 2'd0, 1'b0}) begin
      bad++;
      $display("FAIL first_src0: got %h want %h", {seg_data, seg_com, led, owner, piezo}, {8'h3F, 8'h7F, 8'h01, 2'd0, 1'b0});
    end
  endtask

  task automatic test_ack_in_normal;
    ack_key = 1'b1;
    tick;
    ack_key = 1'b0;
    total++;
    if ({evt_ack, alert_active, seg_data} !== {4'h0, 1'b0, 8'h3F}) begin
      bad++;
      $display("FAIL ack_ignored: got %h want %h", {evt_ack, alert_active, seg_data}, {4'h0, 1'b0, 8'h3F});
    end
    tick;
  endtask

  task automatic test_mode_change;
    int nblank = 0;
    mode_sel = 2'd2;
    for (int i = 0; i < 8; i++) begin
      tick;
      if (seg_com === 8'hFF && seg_data === 8'h00 && led === 8'h00) nblank++;
    end
    total++;
    if (nblank !== 8) begin
      bad++;
      $display("FAIL mode_blank_cycles: got %0d want 8", nblank);
    end
    tick;
    total++;
    if ({seg_data, seg_com, led, owner} !== {8'h5B, 8'hDF, 8'h04, 2'd2}) begin
      bad++;
      $display("FAIL mode_src2: got %h want %h", {seg_data, seg_com, led, owner}, {8'h5B, 8'hDF, 8'h04, 2'd2});
    end
  endtask

  task automatic test_alert_ack;
    int nblank = 0;
    int bad_pz = 0;
    logic exp_pz;
    evt_level[1] = 1'b1;
    tick;
    total++;
    if ({alert_active, seg_data} !== {1'b0, 8'h5B}) begin
      bad++;
      $display("FAIL evt_capture: got %h want %h", {alert_active, seg_data}, {1'b0, 8'h5B});
    end
    for (int i = 0; i < 8; i++) begin
      tick;
      if (seg_com === 8'hFF && seg_data === 8'h00 && alert_active === 1'b0) nblank++;
    end
    total++;
    if (nblank !== 8) begin
      bad++;
      $display("FAIL alert_blank_cycles: got %0d want 8", nblank);
    end
    tick;
    total++;
    if ({alert_active, owner, seg_data, seg_com, piezo} !== {1'b1, 2'd1, 8'h06, 8'hBF, 1'b1}) begin
      bad++;
      $display("FAIL alert_start: got %h want %h", {alert_active, owner, seg_data, seg_com, piezo}, {1'b1, 2'd1, 8'h06, 8'hBF, 1'b1});
    end
    for (int k = 1; k < 500; k++) begin
      tick;
      exp_pz = (k < 250) ? ((k % 2) == 0) : 1'b0;
      if (piezo !== exp_pz) bad_pz++;
    end
    total++;
    if (bad_pz !== 0) begin
      bad++;
      $display("FAIL beep_pattern: got %0d wrong cycles want 0", bad_pz);
    end
    tick;
    total++;
    if (piezo !== 1'b1) begin
      bad++;
      $display("FAIL beep_repeat: got %b want 1", piezo);
    end
    ack_key = 1'b1;
    tick;
    total++;
    if ({evt_ack, piezo, alert_active, seg_com} !== {4'b0010, 1'b0, 1'b0, 8'hFF}) begin
      bad++;
      $display("FAIL ack_end: got %h want %h", {evt_ack, piezo, alert_active, seg_com}, {4'b0010, 1'b0, 1'b0, 8'hFF});
    end
    ack_key = 1'b0;
    evt_level[1] = 1'b0;
    nblank = 0;
    for (int i = 0; i < 7; i++) begin
      tick;
      if (seg_com === 8'hFF && evt_ack === 4'h0 && alert_active === 1'b0) nblank++;
    end
    total++;
    if (nblank !== 7) begin
      bad++;
      $display("FAIL post_ack_blank: got %0d want 7", nblank);
    end
    tick;
    total++;
    if ({owner, seg_data, alert_active} !== {2'd2, 8'h5B, 1'b0}) begin
      bad++;
      $display("FAIL return_owner: got %h want %h", {owner, seg_data, alert_active}, {2'd2, 8'h5B, 1'b0});
    end
  endtask

  task automatic test_timeout;
    int n = 0;
    int nre = 0;
    evt_level[1] = 1'b1;
    repeat (9) tick;
    tick;
    total++;
    if ({alert_active, owner} !== {1'b1, 2'd1}) begin
      bad++;
      $display("FAIL timeout_start: got %h want %h", {alert_active, owner}, {1'b1, 2'd1});
    end
    while (evt_ack === 4'h0 && n < 31000) begin
      tick;
      n++;
    end
    total++;
    if (n !== 30000 || evt_ack !== 4'b0010) begin
      bad++;
      $display("FAIL timeout_len: got cycles=%0d ack=%b want cycles=30000 ack=0010", n, evt_ack);
    end
    repeat (8) tick;
    total++;
    if ({owner, alert_active} !== {2'd2, 1'b0}) begin
      bad++;
      $display("FAIL timeout_return: got %h want %h", {owner, alert_active}, {2'd2, 1'b0});
    end
    repeat (20) begin
      tick;
      if (alert_active !== 1'b0 || owner !== 2'd2) nre++;
    end
    total++;
    if (nre !== 0) begin
      bad++;
      $display("FAIL no_retrigger: got %0d bad cycles want 0", nre);
    end
    evt_level[1] = 1'b0;
    tick;
  endtask

  task automatic test_rr_simultaneous;
    int nblank = 0;
    rst = 1'b1;
    mode_sel = 2'd0;
    tick;
    rst = 1'b0;
    tick;
    evt_level = 4'b1001;
    repeat (9) tick;
    tick;
    total++;
    if ({alert_active, owner, seg_data} !== {1'b1, 2'd0, 8'h3F}) begin
      bad++;
      $display("FAIL rr_first: got %h want %h", {alert_active, owner, seg_data}, {1'b1, 2'd0, 8'h3F});
    end
    ack_key = 1'b1;
    tick;
    ack_key = 1'b0;
    total++;
    if (evt_ack !== 4'b0001) begin
      bad++;
      $display("FAIL rr_ack0: got %b want 0001", evt_ack);
    end
    for (int i = 0; i < 7; i++) begin
      tick;
      if (seg_com === 8'hFF && alert_active === 1'b0) nblank++;
    end
    total++;
    if (nblank !== 7) begin
      bad++;
      $display("FAIL rr_gap_blank: got %0d want 7", nblank);
    end
    tick;
    total++;
    if ({alert_active, owner, seg_data, piezo, evt_ack} !== {1'b1, 2'd3, 8'h4F, 1'b1, 4'h0}) begin
      bad++;
      $display("FAIL rr_second: got %h want %h", {alert_active, owner, seg_data, piezo, evt_ack}, {1'b1, 2'd3, 8'h4F, 1'b1, 4'h0});
    end
    ack_key = 1'b1;
    tick;
    ack_key = 1'b0;
    total++;
    if (evt_ack !== 4'b1000) begin
      bad++;
      $display("FAIL rr_ack3: got %b want 1000", evt_ack);
    end
    repeat (8) tick;
    total++;
    if ({owner, alert_active, seg_data} !== {2'd0, 1'b0, 8'h3F}) begin
      bad++;
      $display("FAIL rr_return: got %h want %h", {owner, alert_active, seg_data}, {2'd0, 1'b0, 8'h3F});
    end
    evt_level = 4'h0;
    tick;
  endtask

  task automatic test_reset_mid_alert;
    evt_level[2] = 1'b1;
    repeat (9) tick;
    tick;
    total++;
    if ({alert_active, owner, piezo} !== {1'b1, 2'd2, 1'b1}) begin
      bad++;
      $display("FAIL pre_reset_alert: got %h want %h", {alert_active, owner, piezo}, {1'b1, 2'd2, 1'b1});
    end
    #1 rst = 1'b1;
    #1;
    total++;
    if ({piezo, seg_com, alert_active, owner} !== {1'b0, 8'hFF, 1'b0, 2'd0}) begin
      bad++;
      $display("FAIL async_reset: got %h want %h", {piezo, seg_com, alert_active, owner}, {1'b0, 8'hFF, 1'b0, 2'd0});
    end
    evt_level = 4'h0;
    @(negedge clk);
    rst = 1'b0;
    tick;
  endtask

  initial begin
    sd[0] = 8'h3F; sd[1] = 8'h06; sd[2] = 8'h5B; sd[3] = 8'h4F;
    sc[0] = 8'h7F; sc[1] = 8'hBF; sc[2] = 8'hDF; sc[3] = 8'hEF;
    sl[0] = 8'h01; sl[1] = 8'h02; sl[2] = 8'h04; sl[3] = 8'h08;
    test_reset;
    test_ack_in_normal;
    test_mode_change;
    test_alert_ack;
    test_timeout;
    test_rr_simultaneous;
    test_reset_mid_alert;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/display_alert_arbiter.md
Name: display_alert_arbiter

Overview:
Shares the single 8-digit 7-segment bank, the 8 LEDs and the piezo among four function blocks: 0=clock, 1=timer, 2=alarm, 3=stopwatch. In normal operation the DIP-selected block owns the display. A rising edge on any block's event line (for example the timer's done output) preempts the display and starts a piezo beep pattern. The alert ends on a user acknowledge or a timeout. The block sits in the top level between the function blocks and the board pins, clocked at 1 kHz.

Parameters:
BLANK_CYC, 8, cycles the display is blanked on every owner change (anti-ghosting; covers one full scan of 8 digits)
BEEP_ON_MS, 250, piezo active phase length in clk cycles
BEEP_OFF_MS, 250, piezo silent phase length in clk cycles
ALERT_MAX_MS, 30000, alert auto-timeout in clk cycles
TONE_DIV, 1, piezo toggles every TONE_DIV cycles during the active phase (1 gives a 500 Hz square wave)

Ports:
clk  in  1  1 kHz system clock
rst  in  1  asynchronous, active-high reset
mode_sel  in  2  DIP-selected normal owner
src_seg_data  in  32  packed seg_data of sources; source i occupies bits [8i+7:8i]
src_seg_com  in  32  packed seg_com of sources, same packing
src_led  in  32  packed led of sources, same packing
evt_level  in  4  per-source event level (e.g. timer_done_out); only rising edges are used
ack_key  in  1  user acknowledge push-button, level, already debounced
seg_data  out  8  to board segment data
seg_com  out  8  to board digit commons, active-low
led  out  8  to board LEDs
piezo  out  1  to board piezo
owner  out  2  current display owner
alert_active  out  1  high while in ALERT
evt_ack  out  4  one-cycle pulse to source i when its alert ends

Behaviour:
- Reset is clk-independent.
  - Reset values: seg_data=0x00, seg_com=0xFF, led=0x00, piezo=0, owner=0, alert_active=0, evt_ack=0.
  - Internal state: pending=0, rr_ptr=3, state=NORMAL.
  - Edge-detect registers are reset to 0, so an event line already high at reset release counts as an edge.
  - Reset mid-alert silences piezo immediately.
- Event detection:
  - pend[i] is set on a 0->1 transition of evt_level[i].
  - pend[i] is cleared when alert i ends.
  - A set and a clear on the same bit in the same cycle: set wins.
  - ack_key is edge-detected the same way; only its rising edge counts.
- States are NORMAL, BLANK and ALERT.
- NORMAL:
  - Outputs are the registered copies of source[owner] buses, so there is 1-cycle latency from source to pin.
  - alert_active=0, piezo=0.
  - If any pend bit is set, select the next source round-robin: search rr_ptr+1 upward modulo 4. Set rr_ptr to the pick, set owner to the pick, and go to BLANK with target=ALERT.
  - Otherwise, if mode_sel != owner, set owner=mode_sel and go to BLANK with target=NORMAL.
  - Pending events take precedence over a mode change.
- BLANK:
  - Drives seg_com=0xFF, seg_data=0x00 and led=0x00 for exactly BLANK_CYC cycles, then enters the target state.
  - New events arriving during BLANK only set pend bits.
- ALERT:
  - Outputs come from source[owner]; alert_active=1.
  - Beep counter: active phase for BEEP_ON_MS cycles, during which piezo toggles every TONE_DIV cycles, starting at 1 on the first ALERT cycle.
  - Silent phase for BEEP_OFF_MS cycles with piezo=0, then repeat.
  - An ack_key rising edge or the elapsed counter reaching ALERT_MAX_MS ends the alert:
    - evt_ack[owner]=1 for one cycle;
    - pend[owner] is cleared;
    - piezo=0 on the next cycle;
    - beep and elapsed counters are cleared;
    - the block then goes to BLANK.
  - After the alert's BLANK:
    - if other pend bits are set, the next alert is selected by the same round-robin rule;
    - else owner=mode_sel and the block returns to NORMAL.
  - mode_sel changes during ALERT are ignored until the return.
  - ack_key while not in ALERT is ignored.
- Counter widths:
  - elapsed counter: 16 bits;
  - beep counter: 10 bits;
  - BLANK counter: 4 bits.
  - All counters saturate or clear as specified and never wrap inside a state.

Test Plan:
- Reset with mode_sel=0, source0 seg_data=0x3F and seg_com=0x7F: after reset release, seg_data=0x3F and seg_com=0x7F one cycle after the source is sampled; owner=0, piezo=0.
- Change mode_sel 0->2 in NORMAL: exactly 8 cycles of seg_com=0xFF and seg_data=0x00, then source2 buses appear; owner=2.
- evt_level[1] rises with mode_sel=2:
  - after 8 blank cycles, alert_active=1, owner=1;
  - piezo toggles each cycle for 250 cycles, then is 0 for 250 cycles;
  - ack_key pulse gives evt_ack=4'b0010 for one cycle, 8 blank cycles, then owner=2.
- evt_level[1] held high with no ack: alert ends at cycle 30000, evt_ack[1] pulses, and there is no re-trigger while the level stays high.
- evt_level[0] and evt_level[3] rise in the same cycle with rr_ptr=3: source 0 is served first, then source 3 after its ack; no NORMAL period in between.
- Assert rst in mid-ALERT while piezo=1: piezo=0, seg_com=0xFF, alert_active=0 immediately, independent of clk.
